wb_wport_arbiter: RTL and testbench

//  Owns the single register-file write port at the writeback stage and shares it between two requesters:
//   - the in-order pipeline stream (ME->WB bus);
//   - the completion port of the multi-cycle divide unit (DIV).

---
 rtl/wb_wport_arbiter_pkg.sv | 49 ++++
 rtl/wb_wport_arbiter_if.sv | 49 ++++
 rtl/wb_wport_arbiter_grant_ctl.sv | 44 ++++
 rtl/wb_wport_arbiter.sv | 73 +++++++
 tb/tb_wb_wport_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_wport_arbiter_pkg.sv
// Writeback write-port arbiter: shared bus widths, field offsets
// and the unpacked request record used by the arbiter.
package wb_wport_arbiter_pkg;

  localparam int ME_WB_BUS_W = 70;
  localparam int DIV_BUS_W   = 69;
  localparam int WB_RF_BUS_W = 38;

  localparam int PC_W   = 32;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam int ME_PC_LSB  = 38;
  localparam int ME_WE_BIT  = 37;
  localparam int DIV_PC_LSB = 37;
  localparam int DEST_LSB   = 32;
  localparam int DATA_LSB   = 0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic wb_req_t me_unpack(
    input logic [ME_WB_BUS_W-1:0] b
  );
    wb_req_t r;
    r.pc   = b[ME_PC_LSB +: PC_W];
    r.we   = b[ME_WE_BIT];
    r.dest = b[DEST_LSB +: REG_W];
    r.data = b[DATA_LSB +: DATA_W];
    return r;
  endfunction

  // The divider only completes register-writing ops.
  function automatic wb_req_t div_unpack(
    input logic [DIV_BUS_W-1:0] b
  );
    wb_req_t r;
    r.pc   = b[DIV_PC_LSB +: PC_W];
    r.we   = 1'b1;
    r.dest = b[DEST_LSB +: REG_W];
    r.data = b[DATA_LSB +: DATA_W];
    return r;
  endfunction

endpackage

// File: rtl/wb_wport_arbiter_if.sv
// Writeback port bundle: pipe and divider requests in,
// register-file write bus and debug trace out.
interface wb_wport_arbiter_if;
  import wb_wport_arbiter_pkg::*;

  logic                   ME_to_WB_Valid;
  logic [ME_WB_BUS_W-1:0] ME_to_WB_Bus;
  logic                   WB_Allow_in;
  logic                   DIV_Valid;
  logic [DIV_BUS_W-1:0]   DIV_Bus;
  logic                   DIV_Ready;
  logic [WB_RF_BUS_W-1:0] WB_to_RF_Bus;
  logic [REG_W-1:0]       WB_dest;
  logic [PC_W-1:0]        debug_wb_pc;
  logic [3:0]             debug_wb_rf_we;
  logic [REG_W-1:0]       debug_wb_rf_wnum;
  logic [DATA_W-1:0]      debug_wb_rf_wdata;

  modport master (
    output ME_to_WB_Valid,
    output ME_to_WB_Bus,
    output DIV_Valid,
    output DIV_Bus,
    input  WB_Allow_in,
    input  DIV_Ready,
    input  WB_to_RF_Bus,
    input  WB_dest,
    input  debug_wb_pc,
    input  debug_wb_rf_we,
    input  debug_wb_rf_wnum,
    input  debug_wb_rf_wdata
  );

  modport slave (
    input  ME_to_WB_Valid,
    input  ME_to_WB_Bus,
    input  DIV_Valid,
    input  DIV_Bus,
    output WB_Allow_in,
    output DIV_Ready,
    output WB_to_RF_Bus,
    output WB_dest,
    output debug_wb_pc,
    output debug_wb_rf_we,
    output debug_wb_rf_wnum,
    output debug_wb_rf_wdata
  );

endinterface

// File: rtl/wb_wport_arbiter_grant_ctl.sv
// Write-port grant: pipe priority, WAW ordering for the
// older divider result, and a starvation override.
module wport_grant_ctl
  import wb_wport_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_valid,
  input  logic [REG_W-1:0] pipe_dest,
  input  logic             div_valid,
  input  logic [REG_W-1:0] div_dest,
  output logic             pipe_grant,
  output logic             div_grant
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             waw;

  always_comb begin
    starved    = (starve_cnt >= LIMIT);
    waw        = (div_dest == pipe_dest) &&
                 (pipe_dest != '0);
    div_grant  = !reset && div_valid &&
                 (!pipe_valid || starved || waw);
    pipe_grant = !reset && pipe_valid && !div_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (div_grant || !div_valid) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_wport_arbiter.sv
// Writeback register-file write port shared by the in-order
// pipe and the divider; one registered write per cycle.
module wb_wport_arbiter
  import wb_wport_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  wb_wport_arbiter_if.slave  wb
);

  wb_req_t pipe_req;
  wb_req_t div_req;
  wb_req_t sel_req;
  wb_req_t out_q;
  logic    out_valid;
  logic    pipe_grant;
  logic    div_grant;
  logic    any_grant;
  logic    rf_we;

  assign pipe_req = me_unpack(wb.ME_to_WB_Bus);
  assign div_req  = div_unpack(wb.DIV_Bus);

  wport_grant_ctl #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_grant (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (wb.ME_to_WB_Valid),
    .pipe_dest  (pipe_req.dest),
    .div_valid  (wb.DIV_Valid),
    .div_dest   (div_req.dest),
    .pipe_grant (pipe_grant),
    .div_grant  (div_grant)
  );

  always_comb begin
    any_grant = pipe_grant || div_grant;
    sel_req   = div_grant ? div_req : pipe_req;
  end

  // Payload holds between grants; only out_valid gates the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      out_valid <= any_grant;
      if (any_grant) begin
        out_q <= sel_req;
      end
    end
  end

  assign rf_we = out_valid && out_q.we &&
                 (out_q.dest != '0);

  assign wb.WB_Allow_in       = !reset && !div_grant;
  assign wb.DIV_Ready         = div_grant;
  assign wb.WB_to_RF_Bus      = {rf_we, out_q.dest,
                                 out_q.data};
  assign wb.WB_dest           = out_valid ? out_q.dest
                                          : '0;
  assign wb.debug_wb_pc       = out_q.pc;
  assign wb.debug_wb_rf_we    = {4{rf_we}};
  assign wb.debug_wb_rf_wnum  = out_q.dest;
  assign wb.debug_wb_rf_wdata = out_q.data;

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Bench for wb_wport_arbiter: directed scenarios plus random
// requesters checked against a cycle-level reference model.
module tb_wb_wport_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_wport_arbiter_if bus ();

  wb_wport_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [69:0] got,
                     input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: consecutive refusals of a waiting divider
  // result, and the write expected on the RF bus this cycle.
  int          refused = 0;
  bit          m_v = 0;
  logic [31:0] m_pc = '0;
  bit          m_we = 0;
  logic [4:0]  m_dest = '0;
  logic [31:0] m_data = '0;
  bit          last_allow, last_ready;

  task automatic step(
    input bit rst,
    input bit pv, input logic [31:0] ppc, input bit pwe,
    input logic [4:0] pd, input logic [31:0] pdat,
    input bit dv, input logic [31:0] dpc,
    input logic [4:0] dd, input logic [31:0] ddat,
    output bit p_taken, output bit d_taken);
    bit eg_div, eg_pipe, e_we;
    @(negedge clk);
    reset              = rst;
    bus.ME_to_WB_Valid = pv;
    bus.ME_to_WB_Bus   = {ppc, pwe, pd, pdat};
    bus.DIV_Valid      = dv;
    bus.DIV_Bus        = {dpc, dd, ddat};
    #1;
    eg_div  = !rst && dv &&
              (!pv || refused >= LIMIT ||
               (dd == pd && pd != 5'd0));
    eg_pipe = !rst && pv && !eg_div;
    e_we    = m_v && m_we && (m_dest != 5'd0);
    chk("allow_in", bus.WB_Allow_in, !rst && !eg_div);
    chk("div_ready", bus.DIV_Ready, eg_div);
    chk("rf_bus", bus.WB_to_RF_Bus, {e_we, m_dest, m_data});
    chk("wb_dest", bus.WB_dest, m_v ? m_dest : 5'd0);
    chk("dbg_pc", bus.debug_wb_pc, m_pc);
    chk("dbg_we", bus.debug_wb_rf_we, {4{e_we}});
    chk("dbg_wnum", bus.debug_wb_rf_wnum, m_dest);
    chk("dbg_wdata", bus.debug_wb_rf_wdata, m_data);
    last_allow = bus.WB_Allow_in;
    last_ready = bus.DIV_Ready;
    p_taken    = eg_pipe;
    d_taken    = eg_div;
    if (rst) begin
      refused = 0;
      m_v = 0; m_pc = '0; m_we = 0; m_dest = '0; m_data = '0;
    end else begin
      if (dv && !eg_div)
        refused = (refused < LIMIT) ? refused + 1 : LIMIT;
      else
        refused = 0;
      m_v = eg_div || eg_pipe;
      if (eg_div) begin
        m_pc = dpc; m_we = 1; m_dest = dd; m_data = ddat;
      end else if (eg_pipe) begin
        m_pc = ppc; m_we = pwe; m_dest = pd; m_data = pdat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  bit          pt, dt;
  bit          p_v, p_we, d_v;
  logic [31:0] p_pc, p_dat, d_pc, d_dat;
  logic [4:0]  p_d, d_d;

  initial begin
    reset = 1'b1;
    bus.ME_to_WB_Valid = 1'b0;
    bus.ME_to_WB_Bus   = '0;
    bus.DIV_Valid      = 1'b0;
    bus.DIV_Bus        = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // 1: reset held with both requesters valid
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 32'h100, 1, 5'd4, 32'h11, 1, 32'h200,
           5'd6, 32'h22, pt, dt);
      chk("t1_allow", last_allow, 1'b0);
      chk("t1_ready", last_ready, 1'b0);
      chk("t1_bus", bus.WB_to_RF_Bus, 38'h0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pt, dt);
    chk("t1_rfwe", bus.WB_to_RF_Bus[37], 1'b0);

    // 2: pipe-only write
    step(0, 1, 32'h1c000000, 1, 5'd5, 32'hDEADBEEF,
         0, 0, 0, 0, pt, dt);
    chk("t2_bus", bus.WB_to_RF_Bus,
        {1'b1, 5'd5, 32'hDEADBEEF});
    chk("t2_dbg_we", bus.debug_wb_rf_we, 4'hF);
    chk("t2_dest", bus.WB_dest, 5'd5);
    chk("t2_pc", bus.debug_wb_pc, 32'h1c000000);

    // 3: divider starves for four cycles, then forced through
    d_v = 1;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 32'h300 + i, 1, 5'd7, 32'hA0 + i,
           d_v, 32'h400, 5'd3, 32'hD1D1, pt, dt);
      chk($sformatf("t3_ready%0d", i), last_ready, i == 4);
      if (i == 4) begin
        chk("t3_allow", last_allow, 1'b0);
        chk("t3_bus", bus.WB_to_RF_Bus,
            {1'b1, 5'd3, 32'hD1D1});
      end
      if (dt) d_v = 0;
    end

    // 4: same destination, divider result must land first
    step(0, 1, 32'h500, 1, 5'd9, 32'hBBBB,
         1, 32'h600, 5'd9, 32'hCCCC, pt, dt);
    chk("t4_ready", last_ready, 1'b1);
    chk("t4_div", bus.WB_to_RF_Bus, {1'b1, 5'd9, 32'hCCCC});
    step(0, 1, 32'h500, 1, 5'd9, 32'hBBBB,
         0, 0, 0, 0, pt, dt);
    chk("t4_allow", last_allow, 1'b1);
    chk("t4_pipe", bus.WB_to_RF_Bus, {1'b1, 5'd9, 32'hBBBB});

    // 5: write to r0 is swallowed
    step(0, 1, 32'h700, 1, 5'd0, 32'h1, 0, 0, 0, 0, pt, dt);
    chk("t5_bus", bus.WB_to_RF_Bus, {1'b0, 5'd0, 32'h1});
    chk("t5_dbg_we", bus.debug_wb_rf_we, 4'h0);

    // 6: reset while the divider is waiting
    for (int i = 0; i < 2; i++)
      step(0, 1, 32'h800 + i, 1, 5'd2, 32'h80 + i,
           1, 32'h900, 5'd1, 32'h99, pt, dt);
    step(1, 1, 32'h802, 1, 5'd2, 32'h82,
         1, 32'h900, 5'd1, 32'h99, pt, dt);
    chk("t6_bus", bus.WB_to_RF_Bus, 38'h0);
    chk("t6_dest", bus.WB_dest, 5'd0);
    chk("t6_pc", bus.debug_wb_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'h810 + i, 1, 5'd2, 32'h90 + i,
           1, 32'h900, 5'd1, 32'h99, pt, dt);
      chk($sformatf("t6_ready%0d", i), last_ready, i == 4);
    end

    // random requesters obeying hold-until-accepted
    p_v = 0; d_v = 0; pt = 0; dt = 0;
    for (int n = 0; n < 600; n++) begin
      if (!p_v || pt) begin
        p_v   = ($urandom_range(0, 3) != 0);
        p_pc  = $urandom;
        p_we  = ($urandom_range(0, 4) != 0);
        p_d   = 5'($urandom_range(0, 3));
        p_dat = $urandom;
      end
      if (!d_v || dt) begin
        d_v   = ($urandom_range(0, 2) == 0);
        d_pc  = $urandom;
        d_d   = 5'($urandom_range(0, 3));
        d_dat = $urandom;
      end
      step($urandom_range(0, 49) == 0,
           p_v, p_pc, p_we, p_d, p_dat,
           d_v, d_pc, d_d, d_dat, pt, dt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
